// File: rtl/enc_scan_ctrl_if.sv
// Host-side register handshake for the encoder scan controller: read, clear and error flags.
interface enc_scan_ctrl_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned CH_W = $clog2(N_CH);

  logic                rd_req;
  logic [CH_W-1:0]     rd_ch;
  logic                rd_ack;
  logic [CNT_W-1:0]    rd_data;
  logic                clr_req;
  logic [CH_W-1:0]     clr_ch;
  logic                clr_ack;
  logic [N_CH-1:0]     err;
  logic                err_clr;

  modport master (
    output rd_req, rd_ch, clr_req, clr_ch, err_clr,
    input  rd_ack, rd_data, clr_ack, err
  );

  modport slave (
    input  rd_req, rd_ch, clr_req, clr_ch, err_clr,
    output rd_ack, rd_data, clr_ack, err
  );
endinterface

// File: rtl/enc_scan_ctrl.sv
// Round-robin quadrature decoder: N_CH synchronised A/B pairs share one decode/count datapath,
// one channel per clock, with host read/clear handshakes and sticky step-error flags.
module enc_scan_ctrl #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   a,
  input  logic [N_CH-1:0]   b,
  input  logic              scan_en,
  output logic              busy,
  enc_scan_ctrl_if.slave    host
);
  localparam int unsigned CH_W = $clog2(N_CH);
  localparam logic [CH_W:0] N_CH_EXT = (CH_W+1)'(N_CH);
  localparam logic [CH_W-1:0] PTR_LAST = CH_W'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, PRIME, SCAN} state_t;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    ptr_q, ptr_d;
  logic [N_CH-1:0]    a_sync_q [SYNC_STAGES];
  logic [N_CH-1:0]    b_sync_q [SYNC_STAGES];
  logic [N_CH-1:0]    sa, sb;
  logic [1:0]         prev_q [N_CH];
  logic [1:0]         prev_d [N_CH];
  logic [CNT_W-1:0]   cnt_q [N_CH];
  logic [CNT_W-1:0]   cnt_d [N_CH];
  logic [N_CH-1:0]    err_q, err_d;
  logic               busy_q, rd_ack_q, clr_ack_q;
  logic [CNT_W-1:0]   rd_data_q, rd_data_d;
  logic [1:0]         cur, step;
  logic               ptr_last, rd_take, clr_take;

  // Position of an {a,b} pair along the forward cycle 00->10->11->01.
  function automatic logic [1:0] phase(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  function automatic logic ch_ok(input logic [CH_W-1:0] ch);
    return {1'b0, ch} < N_CH_EXT;
  endfunction

  // Synchroniser chains carry no reset; they flush while rst is held.
  always_ff @(posedge clk) begin
    a_sync_q[0] <= a;
    b_sync_q[0] <= b;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      a_sync_q[s] <= a_sync_q[s-1];
      b_sync_q[s] <= b_sync_q[s-1];
    end
  end

  assign sa = a_sync_q[SYNC_STAGES-1];
  assign sb = b_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      prev_q    <= '{default: '0};
      cnt_q     <= '{default: '0};
      err_q     <= '0;
      busy_q    <= 1'b0;
      rd_ack_q  <= 1'b0;
      clr_ack_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      busy_q    <= (state_d != IDLE);
      rd_ack_q  <= rd_take;
      clr_ack_q <= clr_take;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    prev_d    = prev_q;
    cnt_d     = cnt_q;
    err_d     = err_q & ~{N_CH{host.err_clr}};
    rd_data_d = rd_data_q;
    cur       = {sa[ptr_q], sb[ptr_q]};
    step      = phase(cur) - phase(prev_q[ptr_q]);
    ptr_last  = (ptr_q == PTR_LAST);
    rd_take   = host.rd_req & ~rd_ack_q;
    clr_take  = host.clr_req & ~clr_ack_q;

    case (state_q)
      IDLE: begin
        ptr_d = '0;
        if (scan_en) state_d = PRIME;
      end
      PRIME: begin
        prev_d[ptr_q] = cur;
        ptr_d         = ptr_last ? '0 : ptr_q + 1'b1;
        if (ptr_last) state_d = SCAN;
      end
      SCAN: begin
        prev_d[ptr_q] = cur;
        ptr_d         = ptr_last ? '0 : ptr_q + 1'b1;
        case (step)
          2'd1:    cnt_d[ptr_q] = cnt_q[ptr_q] + 1'b1;
          2'd3:    cnt_d[ptr_q] = cnt_q[ptr_q] - 1'b1;
          2'd2:    err_d[ptr_q] = 1'b1;
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase

    // Disabling lets the current visit finish, then parks at channel 0.
    if ((state_q != IDLE) && !scan_en) begin
      state_d = IDLE;
      ptr_d   = '0;
    end

    // Clear overrides a same-cycle decode; reads see the post-update count.
    if (clr_take && ch_ok(host.clr_ch)) cnt_d[host.clr_ch] = '0;
    if (rd_take) rd_data_d = ch_ok(host.rd_ch) ? cnt_d[host.rd_ch] : '0;
  end

  assign busy         = busy_q;
  assign host.rd_ack  = rd_ack_q;
  assign host.rd_data = rd_data_q;
  assign host.clr_ack = clr_ack_q;
  assign host.err     = err_q;
endmodule
